// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, widths, transaction record and the
// golden result function used by both the checker and ALU verification benches.
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int OP_W  = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SLL = 3'd2,
        OP_LSR = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_EQ  = 3'd7
    } alu_op_e;

    // Field order matches the packed first-error capture {op, a, b, res}.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [ALU_W-1:0] res;
    } alu_txn_t;

    function automatic logic [ALU_W-1:0] alu_golden(
        input logic [ALU_W-1:0] a,
        input logic [ALU_W-1:0] b,
        input logic [OP_W-1:0]  op
    );
        logic [ALU_W-1:0] y;
        case (alu_op_e'(op))
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLL:  y = a << b[2:0];
            OP_LSR:  y = a >> b[2:0];
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_EQ:   y = (a == b) ? 8'h01 : 8'h00;
            default: y = 8'h00;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/alu_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module alu_sat_cnt
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

    logic [W-1:0] r_cnt;

    // Count register: clear beats increment, increment stops at the ceiling.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= CNT_ZERO;
        end else if (i_clr) begin
            r_cnt <= CNT_ZERO;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/alu_checker.sv
// Two-stage ALU response monitor: S1 samples the transaction, S2 compares it
// against the golden model and updates counters, coverage and first-error capture.
module alu_checker
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                valid_i,
    input  logic [ALU_W-1:0]    a_i,
    input  logic [ALU_W-1:0]    b_i,
    input  logic [OP_W-1:0]     op_i,
    input  logic [ALU_W-1:0]    res_i,
    input  logic                clear_i,
    output logic                chk_valid_o,
    output logic                mismatch_o,
    output logic [CNT_W-1:0]    txn_cnt_o,
    output logic [CNT_W-1:0]    err_cnt_o,
    output logic                err_flag_o,
    output logic [26:0]         first_err_o,
    output logic [7:0]          cov_o,
    output logic                cov_done_o
);

    logic             r_s1_valid;
    alu_txn_t         r_s1_txn;

    logic             r_chk_valid;
    logic             r_mismatch;
    logic             r_err_flag;
    alu_txn_t         r_first_err;
    logic [7:0]       r_cov;
    logic             r_cov_done;

    logic [ALU_W-1:0] w_expected;
    logic             w_mismatch;
    logic [7:0]       w_cov_next;

    // Stage 1: capture the incoming transaction; clear drops it and anything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_txn   <= '{op: 3'd0, a: 8'h00, b: 8'h00, res: 8'h00};
        end else if (clear_i) begin
            r_s1_valid <= 1'b0;
            r_s1_txn   <= '{op: 3'd0, a: 8'h00, b: 8'h00, res: 8'h00};
        end else begin
            r_s1_valid <= valid_i;
            if (valid_i) begin
                r_s1_txn <= '{op: op_i, a: a_i, b: b_i, res: res_i};
            end
        end
    end

    // Compare the staged result and form the coverage update for this cycle.
    always_comb begin
        w_expected = alu_golden(r_s1_txn.a, r_s1_txn.b, r_s1_txn.op);
        w_mismatch = 1'b0;
        w_cov_next = r_cov;
        if (r_s1_valid) begin
            w_mismatch = (w_expected != r_s1_txn.res);
            w_cov_next = r_cov | (8'd1 << r_s1_txn.op);
        end else begin
            w_mismatch = 1'b0;
            w_cov_next = r_cov;
        end
    end

    // Stage 2: register the check outcome, sticky flag, capture and coverage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chk_valid <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_flag  <= 1'b0;
            r_first_err <= '{op: 3'd0, a: 8'h00, b: 8'h00, res: 8'h00};
            r_cov       <= 8'h00;
            r_cov_done  <= 1'b0;
        end else if (clear_i) begin
            r_chk_valid <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_flag  <= 1'b0;
            r_first_err <= '{op: 3'd0, a: 8'h00, b: 8'h00, res: 8'h00};
            r_cov       <= 8'h00;
            r_cov_done  <= 1'b0;
        end else begin
            r_chk_valid <= r_s1_valid;
            r_mismatch  <= w_mismatch;
            r_cov       <= w_cov_next;
            r_cov_done  <= (w_cov_next == 8'hFF);
            // Only the first mismatch since reset/clear is kept.
            if (w_mismatch && !r_err_flag) begin
                r_first_err <= r_s1_txn;
            end
            if (w_mismatch) begin
                r_err_flag <= 1'b1;
            end
        end
    end

    alu_sat_cnt #(.W(CNT_W)) u_txn_cnt (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clr   (clear_i),
        .i_inc   (r_s1_valid),
        .o_cnt   (txn_cnt_o)
    );

    alu_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clr   (clear_i),
        .i_inc   (w_mismatch),
        .o_cnt   (err_cnt_o)
    );

    assign chk_valid_o = r_chk_valid;
    assign mismatch_o  = r_mismatch;
    assign err_flag_o  = r_err_flag;
    assign first_err_o = r_first_err;
    assign cov_o       = r_cov;
    assign cov_done_o  = r_cov_done;

endmodule

// File: tb/tb_alu_checker.sv
// Scoreboard bench for alu_checker: two instances (16-bit and 4-bit counters)
// share one stimulus stream; a reference model predicts every check outcome.
module tb_alu_checker;

    logic        clk;
    logic        reset_n;
    logic        valid_i;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic [2:0]  op_i;
    logic [7:0]  res_i;
    logic        clear_i;

    logic        d16_chk, d16_mm, d16_flag, d16_done;
    logic [15:0] d16_txn, d16_err;
    logic [26:0] d16_first;
    logic [7:0]  d16_cov;
    logic        d4_chk, d4_mm, d4_flag, d4_done;
    logic [3:0]  d4_txn, d4_err;
    logic [26:0] d4_first;
    logic [7:0]  d4_cov;

    alu_checker #(.CNT_W(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
        .op_i(op_i), .res_i(res_i), .clear_i(clear_i),
        .chk_valid_o(d16_chk), .mismatch_o(d16_mm), .txn_cnt_o(d16_txn),
        .err_cnt_o(d16_err), .err_flag_o(d16_flag), .first_err_o(d16_first),
        .cov_o(d16_cov), .cov_done_o(d16_done)
    );

    alu_checker #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
        .op_i(op_i), .res_i(res_i), .clear_i(clear_i),
        .chk_valid_o(d4_chk), .mismatch_o(d4_mm), .txn_cnt_o(d4_txn),
        .err_cnt_o(d4_err), .err_flag_o(d4_flag), .first_err_o(d4_first),
        .cov_o(d4_cov), .cov_done_o(d4_done)
    );

    typedef struct {
        int          due;
        bit          mm;
        int          txn;
        int          err;
        bit          flag;
        logic [26:0] first;
        logic [7:0]  cov;
    } exp_t;

    exp_t q[$];
    exp_t vis;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   flush_seq = 0;
    int   flush_seen = 0;
    bit   done = 1'b0;

    int          m_txn = 0;
    int          m_err = 0;
    bit          m_flag = 1'b0;
    logic [26:0] m_first = 27'd0;
    logic [7:0]  m_cov = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_alu(input int a, input int b, input int op);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return (a * (1 << (b % 8))) % 256;
            3: return a / (1 << (b % 8));
            4: return a & b;
            5: return a | b;
            6: return a ^ b;
            7: return (a == b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flush();
        q.delete();
        m_txn   = 0;
        m_err   = 0;
        m_flag  = 1'b0;
        m_first = 27'd0;
        m_cov   = 8'h00;
        flush_seq++;
    endtask

    // One stimulus cycle: inputs change mid-low-phase, the model predicts the check.
    task automatic drive(input bit v, input int op, input int a, input int b,
                         input int res, input bit clr);
        exp_t it;
        @(negedge clk);
        #2;
        valid_i = v;
        op_i    = op[2:0];
        a_i     = a[7:0];
        b_i     = b[7:0];
        res_i   = res[7:0];
        clear_i = clr;
        if (clr) begin
            flush();
        end else if (v) begin
            it.mm = (ref_alu(a, b, op) != res);
            m_txn++;
            if (it.mm) begin
                if (!m_flag) m_first = {op[2:0], a[7:0], b[7:0], res[7:0]};
                m_flag = 1'b1;
                m_err++;
            end
            m_cov[op] = 1'b1;
            it.due   = cyc + 2;
            it.txn   = m_txn;
            it.err   = m_err;
            it.flag  = m_flag;
            it.first = m_first;
            it.cov   = m_cov;
            q.push_back(it);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    // Monitor: checks every cycle (and right after reset falls) against the scoreboard.
    always @(negedge clk or negedge reset_n) begin
        bit expc;
        #1;
        if (flush_seen != flush_seq) begin
            flush_seen = flush_seq;
            vis.mm = 1'b0; vis.txn = 0; vis.err = 0; vis.flag = 1'b0;
            vis.first = 27'd0; vis.cov = 8'h00; vis.due = 0;
        end
        expc = (q.size() > 0) && (q[0].due == cyc);
        chk("chk_valid16", {31'd0, d16_chk}, {31'd0, expc});
        chk("chk_valid4",  {31'd0, d4_chk},  {31'd0, expc});
        if (expc) begin
            vis = q.pop_front();
            chk("mismatch16", {31'd0, d16_mm}, {31'd0, vis.mm});
            chk("mismatch4",  {31'd0, d4_mm},  {31'd0, vis.mm});
        end
        chk("txn16",   {16'd0, d16_txn}, sat(vis.txn, 65535));
        chk("err16",   {16'd0, d16_err}, sat(vis.err, 65535));
        chk("txn4",    {28'd0, d4_txn},  sat(vis.txn, 15));
        chk("err4",    {28'd0, d4_err},  sat(vis.err, 15));
        chk("flag16",  {31'd0, d16_flag}, {31'd0, vis.flag});
        chk("flag4",   {31'd0, d4_flag},  {31'd0, vis.flag});
        chk("first16", {5'd0, d16_first}, {5'd0, vis.first});
        chk("first4",  {5'd0, d4_first},  {5'd0, vis.first});
        chk("cov16",   {24'd0, d16_cov}, {24'd0, vis.cov});
        chk("cov4",    {24'd0, d4_cov},  {24'd0, vis.cov});
        chk("covdone16", {31'd0, d16_done}, {31'd0, (vis.cov == 8'hFF)});
        chk("covdone4",  {31'd0, d4_done},  {31'd0, (vis.cov == 8'hFF)});
        if (done) begin
            chk("queue_drained", q.size(), 32'd0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        reset_n = 1'b0;
        valid_i = 1'b0; a_i = 8'h00; b_i = 8'h00; op_i = 3'd0; res_i = 8'h00; clear_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;

        // Single ADD that matches.
        drive(1'b1, 0, 8'h0F, 8'h01, 8'h10, 1'b0);
        idle(3);

        // SUB mismatch then SUB match: capture holds the first one.
        drive(1'b0, 0, 0, 0, 0, 1'b1);
        drive(1'b1, 1, 8'h05, 8'h07, 8'h00, 1'b0);
        drive(1'b1, 1, 8'h05, 8'h07, 8'hFE, 1'b0);
        idle(3);

        // All eight opcodes back-to-back, all correct.
        drive(1'b0, 0, 0, 0, 0, 1'b1);
        drive(1'b1, 0, 8'h01, 8'h02, 8'h03, 1'b0);
        drive(1'b1, 1, 8'h10, 8'h01, 8'h0F, 1'b0);
        drive(1'b1, 2, 8'h81, 8'h09, 8'h02, 1'b0);
        drive(1'b1, 3, 8'hF0, 8'h04, 8'h0F, 1'b0);
        drive(1'b1, 4, 8'hF0, 8'h3C, 8'h30, 1'b0);
        drive(1'b1, 5, 8'hF0, 8'h0F, 8'hFF, 1'b0);
        drive(1'b1, 6, 8'hFF, 8'h0F, 8'hF0, 1'b0);
        drive(1'b1, 7, 8'h3C, 8'h3C, 8'h01, 1'b0);
        idle(3);

        // Seventeen mismatches: the 4-bit counters must pin at 4'hF.
        drive(1'b0, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 17; i++) drive(1'b1, 0, 8'h01, 8'h01, 8'h00, 1'b0);
        idle(3);

        // Clear on the edge after a sample, with a new valid alongside.
        drive(1'b1, 3, 8'h80, 8'h01, 8'h40, 1'b0);
        drive(1'b1, 4, 8'hAA, 8'h55, 8'h00, 1'b1);
        idle(3);

        // Reset mid-cycle while S1 holds a transaction.
        drive(1'b1, 6, 8'h12, 8'h34, 8'h26, 1'b0);
        drive(1'b1, 5, 8'h01, 8'h02, 8'h03, 1'b0);
        @(posedge clk);
        #2;
        flush();
        valid_i = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        drive(1'b1, 0, 8'hFF, 8'h01, 8'h00, 1'b0);
        idle(3);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            int op, a, b, r;
            bit v, clr;
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            op  = $urandom_range(0, 7);
            a   = $urandom_range(0, 255);
            b   = (op == 7 && $urandom_range(0, 1) == 1) ? a : $urandom_range(0, 255);
            r   = ($urandom_range(0, 9) < 6) ? ref_alu(a, b, op) : $urandom_range(0, 255);
            drive(v, op, a, b, r, clr);
        end
        idle(4);
        done = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL watchdog: monitor did not finish, got no summary, expected summary");
        $fatal(1, "bench did not terminate");
    end

endmodule
